// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 constants: register numbers, ExcCodes, reset values, entry vector,
// plus the exception priority arbiter used by the M-stage exception unit.
package cp0_exc_unit_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned RADDRW = 5;
   localparam int unsigned EXCW   = 5;
   localparam int unsigned INTW   = 6;

   localparam logic [RADDRW-1:0] CP0_BADVADDR = 5'd8;
   localparam logic [RADDRW-1:0] CP0_COUNT    = 5'd9;
   localparam logic [RADDRW-1:0] CP0_COMPARE  = 5'd11;
   localparam logic [RADDRW-1:0] CP0_STATUS   = 5'd12;
   localparam logic [RADDRW-1:0] CP0_CAUSE    = 5'd13;
   localparam logic [RADDRW-1:0] CP0_EPC      = 5'd14;

   localparam logic [EXCW-1:0] EXC_INT  = 5'h00;
   localparam logic [EXCW-1:0] EXC_ADEL = 5'h04;
   localparam logic [EXCW-1:0] EXC_ADES = 5'h05;
   localparam logic [EXCW-1:0] EXC_SYS  = 5'h08;
   localparam logic [EXCW-1:0] EXC_BP   = 5'h09;
   localparam logic [EXCW-1:0] EXC_RI   = 5'h0a;
   localparam logic [EXCW-1:0] EXC_OV   = 5'h0c;

   localparam logic [XLEN-1:0] STATUS_RESET = 32'h0040_0000;
   localparam logic [XLEN-1:0] EXC_ENTRY    = 32'hBFC0_0380;

   typedef struct packed {
      logic            valid;
      logic [EXCW-1:0] code;
      logic            bad_we;
      logic [XLEN-1:0] bad_addr;
   } exc_sel_t;

   // Highest-priority exception wins; ERET is handled by the caller below all of these.
   function automatic exc_sel_t exc_arbitrate(
      input logic            int_p,
      input logic            fetch_adel,
      input logic            ri,
      input logic            ov,
      input logic            sys,
      input logic            bp,
      input logic            adel_d,
      input logic            ades,
      input logic [XLEN-1:0] pc,
      input logic [XLEN-1:0] badaddr
   );
      exc_sel_t s;
      s       = '0;
      s.valid = 1'b1;
      if (int_p)           s.code = EXC_INT;
      else if (fetch_adel) begin
         s.code     = EXC_ADEL;
         s.bad_we   = 1'b1;
         s.bad_addr = pc;
      end
      else if (ri)         s.code = EXC_RI;
      else if (ov)         s.code = EXC_OV;
      else if (sys)        s.code = EXC_SYS;
      else if (bp)         s.code = EXC_BP;
      else if (adel_d || ades) begin
         s.code     = adel_d ? EXC_ADEL : EXC_ADES;
         s.bad_we   = 1'b1;
         s.bad_addr = badaddr;
      end
      else                 s.valid = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Decoder/M-stage to CP0 exception-unit interface; master drives the instruction
// flags and mtc0/mfc0 requests, slave returns read data and flush/redirect.
interface cp0_exc_unit_if;
   import cp0_exc_unit_pkg::*;

   logic              stall_i;
   logic              valid_i;
   logic [XLEN-1:0]   pc_i;
   logic              in_delayslot_i;
   logic              ri_i;
   logic              brek_i;
   logic              syscall_i;
   logic              eret_i;
   logic              ov_i;
   logic              adel_d_i;
   logic              ades_i;
   logic [XLEN-1:0]   badaddr_i;
   logic              cp0_wen_i;
   logic [RADDRW-1:0] waddr_i;
   logic [XLEN-1:0]   wdata_i;
   logic [RADDRW-1:0] raddr_i;
   logic [XLEN-1:0]   rdata_o;
   logic              exc_flush_o;
   logic [XLEN-1:0]   exc_pc_o;

   modport master (
      output stall_i, valid_i, pc_i, in_delayslot_i, ri_i, brek_i, syscall_i, eret_i, ov_i,
             adel_d_i, ades_i, badaddr_i, cp0_wen_i, waddr_i, wdata_i, raddr_i,
      input  rdata_o, exc_flush_o, exc_pc_o
   );

   modport slave (
      input  stall_i, valid_i, pc_i, in_delayslot_i, ri_i, brek_i, syscall_i, eret_i, ov_i,
             adel_d_i, ades_i, badaddr_i, cp0_wen_i, waddr_i, wdata_i, raddr_i,
      output rdata_o, exc_flush_o, exc_pc_o
   );
endinterface

// File: rtl/cp0_count_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, TI latches on a
// Count==Compare match and is cleared only by a Compare write.
module cp0_count_timer
   import cp0_exc_unit_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            count_we_i,
   input  logic            compare_we_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] count_o,
   output logic [XLEN-1:0] compare_o,
   output logic            ti_o
);

   logic            tick_q;
   logic [XLEN-1:0] count_q, count_d;
   logic [XLEN-1:0] compare_q, compare_d;
   logic            ti_q, ti_d;
   logic            match_c;

   // Software writes override the tick and the match in the same cycle.
   always_comb begin
      match_c   = (count_q == compare_q) && (compare_q != '0);
      count_d   = tick_q ? count_q + XLEN'(1) : count_q;
      compare_d = compare_q;
      ti_d      = ti_q | match_c;
      if (count_we_i)   count_d = wdata_i;
      if (compare_we_i) begin
         compare_d = wdata_i;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tick_q    <= 1'b0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         tick_q    <= ~tick_q;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// M-stage exception/interrupt arbiter and CP0 register file (BadVAddr, Count,
// Compare, Status, Cause, EPC); drives pipeline flush and redirect PC.
module cp0_exc_unit
   import cp0_exc_unit_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic [INTW-1:0]   int_i,
   cp0_exc_unit_if.slave     m_if,
   output logic [XLEN-1:0]   status_o,
   output logic [XLEN-1:0]   cause_o,
   output logic [XLEN-1:0]   epc_o
);

   logic [XLEN-1:0] badvaddr_q, badvaddr_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [7:0]      im_q, im_d;
   logic            exl_q, exl_d;
   logic            ie_q, ie_d;
   logic            bd_q, bd_d;
   logic [EXCW-1:0] exccode_q, exccode_d;
   logic [1:0]      ip_sw_q, ip_sw_d;
   logic [INTW-1:0] int_q;

   logic [XLEN-1:0] count_c, compare_c, status_c, cause_c, rdata_c;
   logic            ti_c, int_p_c, go_c, exc_take_c, eret_take_c, wen_c;
   exc_sel_t        sel_c;

   cp0_count_timer u_timer (
      .clk          (clk),
      .resetn       (resetn),
      .count_we_i   (wen_c && (m_if.waddr_i == CP0_COUNT)),
      .compare_we_i (wen_c && (m_if.waddr_i == CP0_COMPARE)),
      .wdata_i      (m_if.wdata_i),
      .count_o      (count_c),
      .compare_o    (compare_c),
      .ti_o         (ti_c)
   );

   assign status_c = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_c  = {bd_q, ti_c, 14'b0, int_q[5] | ti_c, int_q[4:0], ip_sw_q, 1'b0, exccode_q, 2'b0};

   // Arbitration and commit qualification for the M-stage slot.
   always_comb begin
      go_c        = m_if.valid_i && !m_if.stall_i;
      int_p_c     = ie_q && !exl_q && (|(cause_c[15:8] & im_q)) && m_if.valid_i;
      sel_c       = exc_arbitrate(int_p_c, m_if.pc_i[1:0] != 2'b00, m_if.ri_i, m_if.ov_i,
                                  m_if.syscall_i, m_if.brek_i, m_if.adel_d_i, m_if.ades_i,
                                  m_if.pc_i, m_if.badaddr_i);
      exc_take_c  = go_c && sel_c.valid;
      eret_take_c = go_c && m_if.eret_i && !sel_c.valid;
      wen_c       = go_c && m_if.cp0_wen_i && !sel_c.valid;
   end

   always_comb begin
      badvaddr_d = badvaddr_q;
      epc_d      = epc_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      exccode_d  = exccode_q;
      ip_sw_d    = ip_sw_q;
      if (wen_c) begin
         case (m_if.waddr_i)
            CP0_STATUS: begin
               im_d  = m_if.wdata_i[15:8];
               exl_d = m_if.wdata_i[1];
               ie_d  = m_if.wdata_i[0];
            end
            CP0_CAUSE:  ip_sw_d = m_if.wdata_i[9:8];
            CP0_EPC:    epc_d   = m_if.wdata_i;
            default:    ;
         endcase
      end
      // A nested exception while EXL is set keeps the original EPC/BD.
      if (exc_take_c) begin
         if (!exl_q) begin
            epc_d = m_if.in_delayslot_i ? m_if.pc_i - XLEN'(4) : m_if.pc_i;
            bd_d  = m_if.in_delayslot_i;
         end
         exccode_d = sel_c.code;
         exl_d     = 1'b1;
         if (sel_c.bad_we) badvaddr_d = sel_c.bad_addr;
      end
      if (eret_take_c) exl_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         badvaddr_q <= '0;
         epc_q      <= '0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         exccode_q  <= '0;
         ip_sw_q    <= '0;
         int_q      <= '0;
      end else begin
         badvaddr_q <= badvaddr_d;
         epc_q      <= epc_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         exccode_q  <= exccode_d;
         ip_sw_q    <= ip_sw_d;
         int_q      <= int_i;
      end
   end

   always_comb begin
      rdata_c = '0;
      case (m_if.raddr_i)
         CP0_BADVADDR: rdata_c = badvaddr_q;
         CP0_COUNT:    rdata_c = count_c;
         CP0_COMPARE:  rdata_c = compare_c;
         CP0_STATUS:   rdata_c = status_c;
         CP0_CAUSE:    rdata_c = cause_c;
         CP0_EPC:      rdata_c = epc_q;
         default:      rdata_c = '0;
      endcase
   end

   assign m_if.rdata_o     = rdata_c;
   assign m_if.exc_flush_o = exc_take_c || eret_take_c;
   assign m_if.exc_pc_o    = exc_take_c ? EXC_ENTRY : (eret_take_c ? epc_q : '0);
   assign status_o         = status_c;
   assign cause_o          = cause_c;
   assign epc_o            = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: directed M-stage instructions and CP0 reads
// push hand-computed expectations; a negedge monitor pops and compares.
module tb_cp0_exc_unit;
   import cp0_exc_unit_pkg::*;

   typedef struct packed { logic flush; logic [31:0] pc; } flush_exp_t;
   typedef struct packed { logic [4:0] a; logic [31:0] v; logic [31:0] m; } rd_exp_t;

   localparam logic [9:0] F_RI    = 10'h001;
   localparam logic [9:0] F_BRK   = 10'h002;
   localparam logic [9:0] F_SYS   = 10'h004;
   localparam logic [9:0] F_ERET  = 10'h008;
   localparam logic [9:0] F_OV    = 10'h010;
   localparam logic [9:0] F_ADEL  = 10'h020;
   localparam logic [9:0] F_ADES  = 10'h040;
   localparam logic [9:0] F_DS    = 10'h080;
   localparam logic [9:0] F_WEN   = 10'h100;
   localparam logic [9:0] F_STALL = 10'h200;
   localparam logic [31:0] FULL   = 32'hFFFF_FFFF;
   localparam logic [31:0] M_CODE = 32'h0000_007C;
   localparam logic [31:0] M_TI   = 32'h4000_8000;

   logic        clk = 1'b0;
   logic        resetn;
   logic [5:0]  int_i;
   logic [31:0] status_o, cause_o, epc_o;
   logic        rd_en;
   int          n_checks = 0;
   int          n_errs   = 0;

   flush_exp_t flush_q[$];
   rd_exp_t    rd_q[$];
   flush_exp_t mon_f;
   rd_exp_t    mon_r;

   cp0_exc_unit_if bus();

   cp0_exc_unit dut (
      .clk      (clk),
      .resetn   (resetn),
      .int_i    (int_i),
      .m_if     (bus),
      .status_o (status_o),
      .cause_o  (cause_o),
      .epc_o    (epc_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: instruction slots produce flush/redirect, read requests produce rdata.
   always @(negedge clk) begin
      if (resetn) begin
         if (bus.valid_i) begin
            if (flush_q.size() == 0) chk("unexpected_instr", 32'd1, 32'd0);
            else begin
               mon_f = flush_q.pop_front();
               chk("exc_flush", 32'(bus.exc_flush_o), 32'(mon_f.flush));
               chk("exc_pc", bus.exc_pc_o, mon_f.pc);
            end
         end
         if (rd_en) begin
            if (rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
            else begin
               mon_r = rd_q.pop_front();
               chk($sformatf("rdata_reg%0d", mon_r.a), bus.rdata_o & mon_r.m, mon_r.v);
            end
         end
      end
   end

   task automatic drive_idle();
      bus.stall_i = 1'b0;  bus.valid_i = 1'b0;  bus.pc_i = '0;  bus.in_delayslot_i = 1'b0;
      bus.ri_i = 1'b0;     bus.brek_i = 1'b0;   bus.syscall_i = 1'b0;  bus.eret_i = 1'b0;
      bus.ov_i = 1'b0;     bus.adel_d_i = 1'b0; bus.ades_i = 1'b0;     bus.badaddr_i = '0;
      bus.cp0_wen_i = 1'b0; bus.waddr_i = '0;   bus.wdata_i = '0;      bus.raddr_i = '0;
      rd_en = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      drive_idle();
   endtask

   task automatic idle(input int n);
      repeat (n) next_cycle();
   endtask

   task automatic issue(input logic [31:0] pc, input logic [9:0] f, input logic [31:0] bad,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic ef, input logic [31:0] ep);
      next_cycle();
      bus.valid_i = 1'b1;       bus.pc_i = pc;           bus.badaddr_i = bad;
      bus.ri_i = f[0];          bus.brek_i = f[1];       bus.syscall_i = f[2];
      bus.eret_i = f[3];        bus.ov_i = f[4];         bus.adel_d_i = f[5];
      bus.ades_i = f[6];        bus.in_delayslot_i = f[7];
      bus.cp0_wen_i = f[8];     bus.stall_i = f[9];
      bus.waddr_i = wa;         bus.wdata_i = wd;
      flush_q.push_back('{flush: ef, pc: ep});
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      issue(32'h8000_0000, F_WEN, '0, a, d, 1'b0, 32'h0);
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input logic [31:0] m);
      next_cycle();
      bus.raddr_i = a;
      rd_en = 1'b1;
      rd_q.push_back('{a: a, v: exp, m: m});
   endtask

   initial begin
      resetn = 1'b0;
      int_i  = '0;
      drive_idle();
      #12;
      chk("reset_flush", 32'(bus.exc_flush_o), 32'd0);
      chk("reset_exc_pc", bus.exc_pc_o, 32'd0);
      #10 resetn = 1'b1;

      // Reset values and Count advancing once per two cycles.
      rd(CP0_COUNT,  32'd0, FULL);
      rd(CP0_COUNT,  32'd1, FULL);
      rd(CP0_STATUS, 32'h0040_0000, FULL);
      rd(CP0_COUNT,  32'd2, FULL);
      rd(CP0_CAUSE,  32'h0, FULL);
      rd(CP0_EPC,    32'h0, FULL);

      // syscall outside a delay slot, then eret back.
      issue(32'hBFC0_0100, F_SYS, '0, '0, '0, 1'b1, 32'hBFC0_0380);
      rd(CP0_EPC,    32'hBFC0_0100, FULL);
      rd(CP0_CAUSE,  32'h0000_0020, FULL);
      rd(CP0_STATUS, 32'h0040_0002, FULL);
      issue(32'h8000_0004, F_ERET, '0, '0, '0, 1'b1, 32'hBFC0_0100);

      // RI in a delay slot; nested syscall keeps EPC/BD; eret returns to branch.
      issue(32'h8000_0010, F_RI | F_DS, '0, '0, '0, 1'b1, 32'hBFC0_0380);
      rd(CP0_EPC,    32'h8000_000C, FULL);
      rd(CP0_CAUSE,  32'h8000_0028, FULL);
      issue(32'h8000_0020, F_SYS, '0, '0, '0, 1'b1, 32'hBFC0_0380);
      rd(CP0_EPC,    32'h8000_000C, FULL);
      rd(CP0_CAUSE,  32'h8000_0020, FULL);
      issue(32'h8000_0024, F_ERET, '0, '0, '0, 1'b1, 32'h8000_000C);
      rd(CP0_STATUS, 32'h0040_0000, FULL);

      // Stalled syscall is neither flushed nor committed.
      issue(32'h8000_0030, F_SYS | F_STALL, '0, '0, '0, 1'b0, 32'h0);
      rd(CP0_STATUS, 32'h0040_0000, FULL);

      // Status write mask, then hardware interrupt 0 via IM2.
      mtc0(CP0_STATUS, 32'h1234_0401);
      rd(CP0_STATUS, 32'h0040_0401, FULL);
      next_cycle();
      int_i = 6'h01;
      issue(32'h8000_0100, '0, '0, '0, '0, 1'b1, 32'hBFC0_0380);
      rd(CP0_CAUSE,  32'h0000_0400, FULL);
      rd(CP0_EPC,    32'h8000_0100, FULL);
      issue(32'h8000_0104, '0, '0, '0, '0, 1'b0, 32'h0);
      next_cycle();
      int_i = 6'h00;

      // Timer interrupt through IP7, cleared by a Compare write.
      mtc0(CP0_COUNT,   32'h0);
      mtc0(CP0_COMPARE, 32'h10);
      mtc0(CP0_STATUS,  32'h0000_8001);
      rd(CP0_CAUSE, 32'h0, M_TI);
      idle(40);
      rd(CP0_CAUSE, 32'h4000_8000, M_TI);
      issue(32'h8000_0200, '0, '0, '0, '0, 1'b1, 32'hBFC0_0380);
      rd(CP0_CAUSE, 32'h0, M_CODE);
      mtc0(CP0_COMPARE, 32'h1000);
      rd(CP0_CAUSE, 32'h0, M_TI);

      // AdES beats a simultaneous mtc0; then RI over Ov; then fetch AdEL over syscall.
      mtc0(CP0_STATUS, 32'h0);
      issue(32'h8000_0200, F_ADES | F_WEN, 32'h8000_0003, CP0_STATUS, 32'h0000_FF01,
            1'b1, 32'hBFC0_0380);
      rd(CP0_BADVADDR, 32'h8000_0003, FULL);
      rd(CP0_CAUSE,    32'h14, M_CODE);
      rd(CP0_STATUS,   32'h0040_0002, FULL);
      rd(CP0_EPC,      32'h8000_0200, FULL);
      issue(32'h8000_0300, F_RI | F_OV, '0, '0, '0, 1'b1, 32'hBFC0_0380);
      rd(CP0_CAUSE,    32'h28, M_CODE);
      issue(32'h8000_0302, F_SYS, '0, '0, '0, 1'b1, 32'hBFC0_0380);
      rd(CP0_BADVADDR, 32'h8000_0302, FULL);
      rd(CP0_CAUSE,    32'h10, M_CODE);

      // Asynchronous reset in the middle of operation.
      next_cycle();
      #2 resetn = 1'b0;
      #1;
      chk("midreset_status_o", status_o, 32'h0040_0000);
      chk("midreset_epc_o",    epc_o,    32'h0);
      chk("midreset_cause_o",  cause_o,  32'h0);
      #9 resetn = 1'b1;
      rd(CP0_BADVADDR, 32'h0, FULL);
      rd(CP0_COMPARE,  32'h0, FULL);
      next_cycle();

      for (int i = 0; i < 10 && (flush_q.size() != 0 || rd_q.size() != 0); i++) @(posedge clk);
      if (flush_q.size() != 0 || rd_q.size() != 0)
         chk("drain_pending", 32'(flush_q.size() + rd_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Consumes the per-instruction exception and CP0 control flags produced by instruction decode (ri, brek, syscall, eret, cp0_wen, cp0toreg) once the instruction reaches the memory stage. It arbitrates exceptions and interrupts, owns the CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC), and emits the pipeline flush and redirect PC. It is the responding end of the decoder's exception/CP0 interface and sits beside the M stage of the five-stage pipeline.

## Interface
- No parameters. Constants live in the shared header: register numbers, ExcCodes, reset values, entry vector.
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- stall_i  in  1  M stage held; no commit, no register update except Count and IP sampling
- valid_i  in  1  M-stage slot holds a real instruction (not a bubble)
- int_i  in  6  hardware interrupt lines, level
- pc_i  in  32  PC of the M-stage instruction
- in_delayslot_i  in  1  the instruction is in a branch delay slot
- ri_i, brek_i, syscall_i, eret_i, ov_i  in  1 each  decode/ALU exception flags
- adel_d_i, ades_i  in  1 each  data load/store address error; badaddr_i  in  32  faulting data address
- cp0_wen_i  in  1  mtc0 commit; waddr_i  in  5; wdata_i  in  32
- raddr_i  in  5  mfc0 source; rdata_o  out  32  combinational read of the current register value
- exc_flush_o  out  1  flush IF..M this cycle
- exc_pc_o  out  32  redirect target; valid when exc_flush_o=1
- status_o, cause_o, epc_o  out  32 each  current register values

## Operation
- Fetch address error: pc_i[1:0]≠0 → AdEL, BadVAddr=pc_i.
- Priority, highest first: Int(0x00) > fetch AdEL(0x04) > RI(0x0a) > Ov(0x0c) > Sys(0x08) > Bp(0x09) > data AdEL(0x04)/AdES(0x05, BadVAddr=badaddr_i) > ERET.
- Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]), and requires valid_i.
- Exception taken (valid_i & ~stall_i):
  - exc_flush_o=1, exc_pc_o=0xBFC0_0380.
  - If Status.EXL was 0: EPC = in_delayslot_i ? pc_i−4 : pc_i, and Cause.BD = in_delayslot_i.
  - Cause.ExcCode[6:2] set; Status.EXL=1.
- ERET: exc_flush_o=1, exc_pc_o=EPC, Status.EXL cleared.
- mtc0 write masks:
  - Status: IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; other bits read 0.
  - Cause: IP[9:8] only.
  - Compare: full; write also clears Cause.TI.
  - Count: full.
  - EPC: full.
  - BadVAddr: read-only.
- Cause.IP[15:10] ← registered int_i every cycle. IP7 = int_i[5] | Cause.TI.
- Count increments once every two cycles via an internal toggle. Count==Compare (Compare≠0) sets Cause.TI[30]; TI holds until a Compare write.

## Timing
- Reset values: Status=0x0040_0000, all other registers 0, count toggle 0, exc_flush_o=0, exc_pc_o=0.
- exc_flush_o and exc_pc_o are combinational in the same cycle as the M-stage inputs. CP0 updates land at the next rising edge.
- Exception and mtc0 in the same cycle: exception wins, write dropped.
- mtc0 to Count on a tick cycle: the written value wins.
- mtc0 to Compare in the same cycle as a Count==Compare match: TI is cleared.
- stall_i=1: flush suppressed, registers frozen except Count/TI/IP sampling.
- Reset mid-operation restores all reset values asynchronously.

## Structure
- cp0defines.vh, beside exceptiondefines.vh: CP0 register numbers (8, 9, 11, 12, 13, 14), ExcCode values, Status reset value, entry vector 0xBFC0_0380.
- Sub-module cp0_count_timer: Count, Compare, toggle, TI generation.

## Test plan
- Reset, then read Status → 0x0040_0000; Count increments by 1 every 2 cycles.
- syscall_i at pc 0xBFC0_0100, not in delay slot → flush, exc_pc 0xBFC0_0380, EPC 0xBFC0_0100, ExcCode 0x08, EXL=1.
- ri_i with in_delayslot_i at pc 0x8000_0010 → EPC 0x8000_000C, BD=1, ExcCode 0x0a. Then eret_i → exc_pc 0x8000_000C, EXL=0.
- Write Status=0x0000_0401, assert int_i[0] → Int taken at next valid instruction, ExcCode 0. With EXL=1 already set → no interrupt.
- Write Compare=0x10 → TI rises when Count=0x10; Status=0x8001 → Int taken. Writing Compare clears TI.
- ades_i with badaddr 0x8000_0003 and simultaneous cp0_wen_i → BadVAddr 0x8000_0003, ExcCode 0x05, mtc0 dropped. ri_i together with ov_i → ExcCode 0x0a.
